// File: rtl/peak_readout_serializer_pkg.sv
// Shared constants, FSM encoding and helpers for the peak readout serializer.
package peak_readout_serializer_pkg;

   localparam int NP_DEF        = 10;
   localparam int PIXEL_NUM_DEF = 4;
   localparam logic [NP_DEF-1:0] NO_PEAK = {NP_DEF{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

endpackage

// File: rtl/peak_readout_serializer_if.sv
// Valid/ready beat stream carrying one pixel peak result per transfer.
interface peak_readout_serializer_if #(
   parameter int NP   = 10,
   parameter int IDXW = 2
);
   logic            out_valid;
   logic            out_ready;
   logic [IDXW-1:0] out_pixel;
   logic [NP-1:0]   out_data;
   logic            out_hit;
   logic            out_last;

   modport master (output out_valid, out_pixel, out_data, out_hit, out_last, input out_ready);
   modport slave  (input out_valid, out_pixel, out_data, out_hit, out_last, output out_ready);
endinterface

// File: rtl/peak_readout_serializer_frame_buf.sv
// PIXEL_NUM x NP register bank: load from packed vector, copy from another bank, indexed read.
module peak_readout_serializer_frame_buf #(
   parameter int NP        = 10,
   parameter int PIXEL_NUM = 4,
   parameter int IDXW      = 2
) (
   input  logic                      clk,
   input  logic                      load,
   input  logic [NP*PIXEL_NUM-1:0]   load_vec,
   input  logic                      copy,
   input  logic [NP*PIXEL_NUM-1:0]   copy_vec,
   input  logic [IDXW-1:0]           rd_idx,
   output logic [NP-1:0]             rd_data,
   output logic [NP*PIXEL_NUM-1:0]   contents
);

   logic [NP-1:0] bank_r [PIXEL_NUM];

   // Contents are deliberately not reset; occupancy is tracked by the owner.
   always_ff @(posedge clk) begin
      for (int y = 0; y < PIXEL_NUM; y++) begin
         if (load) begin
            bank_r[y] <= load_vec[y*NP +: NP];
         end else if (copy) begin
            bank_r[y] <= copy_vec[y*NP +: NP];
         end else begin
            bank_r[y] <= bank_r[y];
         end
      end
   end

   // Indexed read and packed view for bank-to-bank copies.
   always_comb begin
      rd_data  = bank_r[rd_idx];
      contents = {(NP*PIXEL_NUM){1'b0}};
      for (int y = 0; y < PIXEL_NUM; y++) begin
         contents[y*NP +: NP] = bank_r[y];
      end
   end

endmodule

// File: rtl/peak_readout_serializer.sv
// Captures completed peak-result frames into a double buffer and streams them out one pixel per beat.
module peak_readout_serializer
   import peak_readout_serializer_pkg::*;
#(
   parameter int NP        = NP_DEF,
   parameter int PIXEL_NUM = PIXEL_NUM_DEF,
   parameter int IDXW      = $clog2(PIXEL_NUM)
) (
   input  logic                      clk,
   input  logic                      res,
   input  logic                      frame_valid,
   input  logic [NP*PIXEL_NUM-1:0]   result,
   peak_readout_serializer_if.master beat,
   output logic                      busy,
   output logic                      overrun,
   input  logic                      clr_overrun,
   output logic [7:0]                drop_cnt
);

   state_t          state_r, state_nxt_s;
   logic            pend_full_r, pend_full_nxt_s;
   logic [IDXW-1:0] rd_ptr_r, rd_ptr_nxt_s;
   logic            act_load_s, act_copy_s, pend_load_s, drop_s;
   logic            act_full_s, xfer_s, last_s, last_xfer_s;
   logic [NP-1:0]   act_data_s;
   logic [NP-1:0]   pend_rd_unused_s;
   logic [NP*PIXEL_NUM-1:0] pend_vec_s, act_vec_unused_s;

   assign act_full_s  = (state_r == ST_SEND);
   assign xfer_s      = act_full_s & beat.out_ready;
   assign last_s      = (rd_ptr_r == IDXW'(PIXEL_NUM-1));
   assign last_xfer_s = xfer_s & last_s;

   peak_readout_serializer_frame_buf #(.NP(NP), .PIXEL_NUM(PIXEL_NUM), .IDXW(IDXW)) u_act (
      .clk(clk), .load(act_load_s), .load_vec(result), .copy(act_copy_s), .copy_vec(pend_vec_s),
      .rd_idx(rd_ptr_r), .rd_data(act_data_s), .contents(act_vec_unused_s)
   );

   peak_readout_serializer_frame_buf #(.NP(NP), .PIXEL_NUM(PIXEL_NUM), .IDXW(IDXW)) u_pend (
      .clk(clk), .load(pend_load_s), .load_vec(result), .copy(1'b0),
      .copy_vec({(NP*PIXEL_NUM){1'b0}}), .rd_idx(rd_ptr_r), .rd_data(pend_rd_unused_s),
      .contents(pend_vec_s)
   );

   // Next-state, buffer steering and drop decision, all from the pre-edge state.
   always_comb begin
      state_nxt_s     = state_r;
      pend_full_nxt_s = pend_full_r;
      rd_ptr_nxt_s    = rd_ptr_r;
      act_load_s      = 1'b0;
      act_copy_s      = 1'b0;
      pend_load_s     = 1'b0;
      drop_s          = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (frame_valid) begin
               act_load_s   = 1'b1;
               rd_ptr_nxt_s = {IDXW{1'b0}};
               state_nxt_s  = ST_SEND;
            end else begin
               rd_ptr_nxt_s = {IDXW{1'b0}};
            end
         end
         ST_SEND: begin
            if (last_xfer_s) begin
               rd_ptr_nxt_s = {IDXW{1'b0}};
               if (pend_full_r) begin
                  // Pending frame becomes active with no bubble; a new frame refills pending.
                  act_copy_s      = 1'b1;
                  pend_load_s     = frame_valid;
                  pend_full_nxt_s = frame_valid;
               end else if (frame_valid) begin
                  act_load_s = 1'b1;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               if (xfer_s) begin
                  rd_ptr_nxt_s = rd_ptr_r + IDXW'(1);
               end else begin
                  rd_ptr_nxt_s = rd_ptr_r;
               end
               if (frame_valid && !pend_full_r) begin
                  pend_load_s     = 1'b1;
                  pend_full_nxt_s = 1'b1;
               end else if (frame_valid) begin
                  drop_s = 1'b1;
               end else begin
                  drop_s = 1'b0;
               end
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, pointer, occupancy and drop bookkeeping.
   always_ff @(posedge clk) begin
      if (res) begin
         state_r     <= ST_IDLE;
         pend_full_r <= 1'b0;
         rd_ptr_r    <= {IDXW{1'b0}};
         busy        <= 1'b0;
         overrun     <= 1'b0;
         drop_cnt    <= 8'd0;
      end else begin
         state_r     <= state_nxt_s;
         pend_full_r <= pend_full_nxt_s;
         rd_ptr_r    <= rd_ptr_nxt_s;
         busy        <= (state_nxt_s == ST_SEND) | pend_full_nxt_s;
         if (drop_s) begin
            overrun  <= 1'b1;
            drop_cnt <= sat_inc8(drop_cnt);
         end else if (clr_overrun) begin
            overrun  <= 1'b0;
         end else begin
            overrun  <= overrun;
         end
      end
   end

   // Beat fields decode the registered active entry; idle outputs read as zero.
   always_comb begin
      beat.out_valid = act_full_s;
      if (act_full_s) begin
         beat.out_pixel = rd_ptr_r;
         beat.out_data  = act_data_s;
         beat.out_hit   = (act_data_s != {NP{1'b1}});
         beat.out_last  = last_s;
      end else begin
         beat.out_pixel = {IDXW{1'b0}};
         beat.out_data  = {NP{1'b0}};
         beat.out_hit   = 1'b0;
         beat.out_last  = 1'b0;
      end
   end

endmodule

// File: doc/peak_readout_serializer.md
# peak_readout_serializer

Downstream stage of the SiFH histogram builder. It captures the packed per-pixel peak-result vector when a frame completes and double-buffers it. It then streams the results out one pixel per beat over a valid/ready interface to the host/readout logic. Each beat carries the pixel index, the peak timestamp, a hit flag and a last-of-frame marker. The block also reports frames that had to be dropped because the consumer was too slow.

## Interface
Parameters:
- `NP`, default 10: peak timestamp width (matches `Np`).
- `PIXEL_NUM`, default 4: pixels per RAM (matches `PIXEL_NUM_PER_RAM`); must be ≥ 2.
- `IDXW`, default `$clog2(PIXEL_NUM)`: pixel index width.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `res`, in, 1: synchronous, active-high reset.
- `frame_valid`, in, 1: one-cycle pulse meaning `result` holds a final frame.
- `result`, in, `NP*PIXEL_NUM`: pixel y occupies bits `[y*NP +: NP]`.
- `out_valid`, out, 1: beat available.
- `out_ready`, in, 1: consumer accepts the beat.
- `out_pixel`, out, `IDXW`: pixel index of the beat.
- `out_data`, out, `NP`: peak timestamp.
- `out_hit`, out, 1: high when `out_data != {NP{1'b1}}`. All-ones is the "no valid peak" marker.
- `out_last`, out, 1: high on the beat where `out_pixel == PIXEL_NUM-1`.
- `busy`, out, 1: active buffer or pending buffer occupied.
- `overrun`, out, 1: sticky; set when a frame is dropped.
- `clr_overrun`, in, 1: clears `overrun`.
- `drop_cnt`, out, 8: count of dropped frames; saturates at 255.

## Operation
- Storage:
  - Active buffer `act[PIXEL_NUM]` with `act_full`.
  - Pending buffer `pend[PIXEL_NUM]` with `pend_full`.
  - Read pointer `rd_ptr`.
- States:
  - IDLE: `act_full=0`.
  - SEND: `act_full=1`, emitting `act[rd_ptr]`.
- A transfer (xfer) occurs when `out_valid && out_ready`.
- `frame_valid` handling, evaluated every cycle against the pre-edge state:
  - IDLE: load `act`, set `rd_ptr=0`, go to SEND.
  - SEND with pending empty: load `pend`.
  - SEND with pending full and a last-beat xfer this cycle: move `pend` to `act`, load the new frame into `pend`. No drop.
  - SEND with pending full and no last-beat xfer: drop the new frame. Set `overrun`; increment `drop_cnt` (saturating).
- Transfer handling in SEND:
  - Non-last xfer: `rd_ptr` increments.
  - Last xfer with pending full: `act <= pend`, `rd_ptr <= 0`, stay in SEND. No bubble.
  - Last xfer with pending empty and `frame_valid` high: load `act` directly from `result`, stay in SEND.
  - Last xfer with pending empty and no `frame_valid`: go to IDLE.
- `out_hit` and `out_last` are derived combinationally from the registered `act[rd_ptr]` and `rd_ptr`.
- `clr_overrun` and a drop in the same cycle: the drop wins, so `overrun` stays 1.
- Reset:
  - `out_valid=0`, `out_pixel=0`, `out_data=0`, `out_hit=0`, `out_last=0`, `busy=0`, `overrun=0`, `drop_cnt=0`.
  - Both buffers are marked empty; buffer contents are not cleared.
  - Reset mid-frame discards any partial frame. No further beats are emitted until the next `frame_valid`.

## Timing
- A `frame_valid` sampled at edge t in IDLE gives `out_valid=1` with pixel 0 at edge t+1 (latency 1).
- While `out_valid=1 && out_ready=0`, `out_pixel`, `out_data`, `out_hit` and `out_last` hold stable. `out_valid` never drops without an xfer.
- With `out_ready` tied high, one frame drains in exactly `PIXEL_NUM` cycles.
- Back-to-back frames produce no idle cycle between the last beat of frame N and pixel 0 of frame N+1.
- `busy` is registered and reflects post-edge occupancy.
- `out_valid` is a pure function of `act_full`. It has no combinational path from `out_ready`.

## Structure
- Shared package/header `parametersSiFH.vh` supplies `Np`, `PIXEL_NUM_PER_RAM`, and a new `NO_PEAK` constant (all-ones of `Np`). The block takes these as parameter defaults.
- One sub-module is natural: `frame_buf`, a `PIXEL_NUM×NP` register bank with load-from-packed-vector, copy-from-other-bank and indexed read. It is instantiated twice, for active and pending.
- The control FSM, pointer and counters live in the top level. Target size is about 200 lines.

## Test plan
- **Single frame, ready high:**
  - Stimulus: `result={10'h3FF,10'd7,10'd512,10'd1}`, `frame_valid` pulse.
  - Response: four beats on consecutive cycles, pixels 0..3.
  - Data 1, 512, 7, 0x3FF; hits 1, 1, 1, 0; `out_last` only on pixel 3; then IDLE with `busy=0`.
- **Backpressure:**
  - Stimulus: `out_ready` toggled 0,0,1,0,1,…
  - Response: outputs stay frozen while ready is low; exactly four xfers, in order; no duplicates.
- **Back-to-back:**
  - Stimulus: second `frame_valid` two cycles after the first, with ready high.
  - Response: eight consecutive beats with no gap; frame 2 data is correct.
- **Overrun:**
  - Stimulus: ready held 0, three `frame_valid` pulses.
  - Response: `overrun=1`, `drop_cnt=1`. After releasing ready, frames 1 and 2 drain; frame 3 never appears.
  - Stimulus: pulse `clr_overrun`. Response: `overrun=0`, `drop_cnt` stays 1.
- **Simultaneous last-beat and `frame_valid` with pending full:**
  - Response: no drop; three frames emitted in order.
- **Reset mid-frame:**
  - Stimulus: `res` high after pixel 1 is transferred.
  - Response: next cycle `out_valid=0`, `busy=0`, counters 0; a new frame starts cleanly at pixel 0.
